data_sram_resp: RTL and testbench
=================================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameters SHALL be: MEM_DEPTH_LOG2, default 10, log2 of word count; LATENCY, default 2, range >=1, cycles from a request becoming queue head to data_ok; QUEUE_DEPTH, default 2, power of two, maximum outstanding accepted requests.
REQ-002 The design SHALL use one clock; reset is asynchronous and active-high. Ports are listed below (name, direction, width, meaning).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 data_req  input  1  initiator request strobe.
REQ-006 data_wr  input  1  1=write, 0=read.
REQ-007 data_size  input  2  0=byte, 1=halfword, 2=word; 3 SHALL be treated as word.
REQ-008 data_addr  input  32  byte address.
REQ-009 data_wdata  input  32  write data, byte lanes aligned to address.
REQ-010 data_rdata  output  32  read data, valid only with data_ok on a read.
REQ-011 data_addr_ok  output  1  request accepted this cycle.
REQ-012 data_data_ok  output  1  one-cycle completion pulse for the queue head.

Function
REQ-013 data_addr_ok SHALL be combinational: data_req & ~full. It SHALL be 0 when full, including in a cycle where the head completes.
REQ-014 A request SHALL be accepted in cycle T when data_req & data_addr_ok. Its wr, size, addr and wdata SHALL be captured at the T edge into the queue tail.
REQ-015 Completion SHALL be strictly in acceptance order, with exactly one data_ok pulse per accepted request.
REQ-016 Counter cnt SHALL be 0 whenever the head entry changes or the queue is empty, and SHALL increment each cycle while the head is valid.
REQ-017 data_ok SHALL be 1 iff head valid & cnt==LATENCY-1. On that edge the head SHALL be popped and cnt cleared.
REQ-018 Completion latency: a request accepted into an empty queue in cycle T SHALL complete in cycle T+LATENCY. A queued request SHALL complete LATENCY cycles after its predecessor's data_ok.
REQ-019 A simultaneous accept and pop SHALL leave the occupancy count unchanged. Pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-020 Reads: data_rdata = mem[head addr index] when data_ok & ~head.wr, else 32'h0. The value SHALL be read in the data_ok cycle, so it reflects all earlier completed writes.
REQ-021 Writes SHALL update mem at the data_ok edge under a byte mask.
REQ-022 Byte mask for size 0: lane addr[1:0] (0001/0010/0100/1000).
REQ-023 Byte mask for size 1: 0011 if addr[1]=0, else 1100.
REQ-024 Byte mask for size 2 or 3: 1111.
REQ-025 Unmasked bytes SHALL be preserved.
REQ-026 Word index SHALL be addr[MEM_DEPTH_LOG2+1:2]. Upper address bits SHALL be ignored and alias, and misalignment SHALL NOT be checked.
REQ-027 A read and a write to the same word SHALL complete in queue order, so the read sees the write only if the write was accepted earlier.

Reset
REQ-028 While rst=1: queue empty, pointers 0, cnt 0, data_addr_ok=0, data_data_ok=0, data_rdata=0.
REQ-029 Reset asserted mid-transaction SHALL discard all outstanding requests. No data_ok SHALL be issued for them after reset release.
REQ-030 Memory array contents SHALL NOT be reset. Contents are undefined until written.

Structure
REQ-031 Shared package sram_like_pkg SHALL hold the size encodings (SIZE_BYTE/HALF/WORD) and the request-entry struct (wr, size, addr, wdata).
REQ-032 Request queue SHALL be sub-module req_fifo: parameterised depth, push/pop, full/empty, same-cycle push+pop.
REQ-033 Byte-mask generation SHALL be a package function shared with initiators.

Verification
REQ-034 Reset, then write word 0xDEADBEEF to 0x100, then read 0x100 -> write data_ok at T+2; read returns 0xDEADBEEF.
REQ-035 Word 0x11223344 at 0x200, then sb 0xAA to 0x203, sh 0x5566 to 0x200 -> read 0x200 returns 0xAA225566.
REQ-036 data_req held high with 3 back-to-back reads, QUEUE_DEPTH=2 -> addr_ok high 2 cycles, low while full, third accepted the cycle after first data_ok. data_ok spaced exactly 2 cycles apart, in order.
REQ-037 LATENCY=1, single read accepted in T -> data_ok in T+1 only. Idle afterwards -> no further data_ok.
REQ-038 Write to 0x300 immediately followed by read to 0x300, both queued -> read returns the new value.
REQ-039 rst pulsed while 2 requests outstanding -> outputs 0 during reset, zero data_ok after release, next request completes with nominal latency.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like data interface: size encodings,
// the queued request record and the byte-lane mask helper used by both sides.
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_entry_t;

  // Encoding 3 falls into the default arm and behaves as a full word.
  function automatic logic [3:0] byte_mask(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << addr_lo;
      SIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// In-order request queue with registered pointers and occupancy; the head
// entry is presented combinationally and a push and pop may share one cycle.
module req_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  req_entry_t push_data_i,
  input  logic       pop_i,
  output req_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  req_entry_t         slots_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage carries no reset; validity is tracked by the pointers and
  // count alone, which keeps the array mappable onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (push_i) slots_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = slots_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/data_sram_resp.sv
// SRAM-like data-port responder: queues accepted requests and completes each
// one a fixed LATENCY after it reaches the queue head, strictly in order.
module data_sram_resp
  import sram_like_pkg::*;
#(
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int LATENCY        = 2,
  parameter int QUEUE_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  req_entry_t                push_entry, head;
  logic                      push, pop, full, empty;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [MEM_DEPTH_LOG2-1:0] head_idx;
  logic [3:0]                head_mask;
  logic [31:0]               mem_q [2**MEM_DEPTH_LOG2];
  logic                      unused_addr_hi;

  assign push_entry = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

  // Acceptance is held off during reset so nothing slips in on release.
  assign data_addr_ok = data_req & ~full & ~rst;
  assign push         = data_addr_ok;
  assign pop          = ~empty & (cnt_q == CNT_LAST);
  assign data_data_ok = pop;

  req_fifo #(
    .DEPTH(QUEUE_DEPTH)
  ) u_req_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d = '0;
    if (!empty && !pop) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign head_idx       = head.addr[MEM_DEPTH_LOG2+1:2];
  assign head_mask      = byte_mask(head.size, head.addr[1:0]);
  assign unused_addr_hi = ^head.addr[31:MEM_DEPTH_LOG2+2];

  always_ff @(posedge clk) begin
    if (pop && head.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (head_mask[b]) mem_q[head_idx][8*b +: 8] <= head.wdata[8*b +: 8];
      end
    end
  end

  // Read in the completion cycle so earlier completed writes are visible.
  assign data_rdata = (pop && !head.wr) ? mem_q[head_idx] : 32'h0;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: a vector table of single transactions plus
// hand-written back-to-back, reset-abort and LATENCY=1 sequences.
module tb_data_sram_resp;
  import sram_like_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req1, wr1, req2, wr2;
  logic [1:0]  size1, size2;
  logic [31:0] addr1, wdata1, addr2, wdata2, rdata1, rdata2;
  logic        aok1, dok1, aok2, dok2;

  data_sram_resp #(.MEM_DEPTH_LOG2(10), .LATENCY(2), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .data_req(req1), .data_wr(wr1), .data_size(size1),
    .data_addr(addr1), .data_wdata(wdata1), .data_rdata(rdata1),
    .data_addr_ok(aok1), .data_data_ok(dok1)
  );

  data_sram_resp #(.MEM_DEPTH_LOG2(10), .LATENCY(1), .QUEUE_DEPTH(2)) dut_l1 (
    .clk(clk), .rst(rst), .data_req(req2), .data_wr(wr2), .data_size(size2),
    .data_addr(addr2), .data_wdata(wdata2), .data_rdata(rdata2),
    .data_addr_ok(aok2), .data_data_ok(dok2)
  );

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  logic        cur_aok, cur_dok;
  logic [31:0] cur_rdata;
  always_comb begin
    cur_aok   = (sel == 0) ? aok1   : aok2;
    cur_dok   = (sel == 0) ? dok1   : dok2;
    cur_rdata = (sel == 0) ? rdata1 : rdata2;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [12];
  vec_t        bq [$];
  int          dok_cyc [$];
  logic [31:0] rd_log [$];
  logic        aok_log [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      req1 = r; wr1 = w; size1 = s; addr1 = a; wdata1 = d;
    end else begin
      req2 = r; wr2 = w; size2 = s; addr2 = a; wdata2 = d;
    end
  endtask

  // One request into an empty queue; measures cycles from acceptance to data_ok.
  task automatic single(input vec_t v, input int exp_lat, input string tag);
    int          lat;
    logic [31:0] rd;
    lat = 0;
    rd  = 32'hxxxx_xxxx;
    @(posedge clk); #1;
    drive(1'b1, v.wr, v.size, v.addr, v.wdata);
    @(negedge clk);
    check({tag, " addr_ok"}, 32'(cur_aok), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (cur_dok) begin
        lat = k;
        rd  = cur_rdata;
        break;
      end
      @(posedge clk);
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, rd, v.exp_rdata);
  endtask

  // Holds data_req high until every entry of bq is accepted; logs per cycle.
  task automatic burst(input int ncyc);
    int n;
    n = 0;
    dok_cyc.delete();
    rd_log.delete();
    aok_log.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (n < bq.size()) drive(1'b1, bq[n].wr, bq[n].size, bq[n].addr, bq[n].wdata);
      else               drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      @(negedge clk);
      aok_log.push_back(cur_aok);
      if (cur_dok) begin
        dok_cyc.push_back(c);
        rd_log.push_back(cur_rdata);
      end
      if (n < bq.size() && cur_aok) n++;
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.wr = w; v.size = s; v.addr = a; v.wdata = d; v.exp_rdata = e;
    return v;
  endfunction

  initial begin
    int ndok;

    vecs[0]  = mk(1'b1, SIZE_WORD, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0);
    vecs[1]  = mk(1'b0, SIZE_WORD, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF);
    vecs[2]  = mk(1'b1, SIZE_WORD, 32'h0000_0200, 32'h1122_3344, 32'h0);
    vecs[3]  = mk(1'b1, SIZE_BYTE, 32'h0000_0203, 32'hAA00_0000, 32'h0);
    vecs[4]  = mk(1'b1, SIZE_HALF, 32'h0000_0200, 32'h0000_5566, 32'h0);
    vecs[5]  = mk(1'b0, SIZE_WORD, 32'h0000_0200, 32'h0,         32'hAA22_5566);
    vecs[6]  = mk(1'b1, SIZE_BYTE, 32'h0000_0201, 32'h0000_7700, 32'h0);
    vecs[7]  = mk(1'b0, SIZE_WORD, 32'h0000_0200, 32'h0,         32'hAA22_7766);
    vecs[8]  = mk(1'b1, SIZE_HALF, 32'h0000_0202, 32'h9988_0000, 32'h0);
    vecs[9]  = mk(1'b0, SIZE_WORD, 32'h0000_0200, 32'h0,         32'h9988_7766);
    vecs[10] = mk(1'b1, 2'd3,      32'h0000_1204, 32'h1234_5678, 32'h0);
    vecs[11] = mk(1'b0, SIZE_WORD, 32'h0000_0204, 32'h0,         32'h1234_5678);

    // Reset with requests asserted on both instances.
    rst = 1'b1;
    req1 = 1'b1; wr1 = 1'b0; size1 = 2'd2; addr1 = 32'h100; wdata1 = 32'h0;
    req2 = 1'b1; wr2 = 1'b0; size2 = 2'd2; addr2 = 32'h100; wdata2 = 32'h0;
    repeat (2) @(negedge clk);
    check("reset addr_ok", 32'(aok1), 32'd0);
    check("reset data_ok", 32'(dok1), 32'd0);
    check("reset rdata",   rdata1,    32'h0);
    check("reset addr_ok l1", 32'(aok2), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req1 = 1'b0;
    req2 = 1'b0;

    for (int i = 0; i < 12; i++) single(vecs[i], 2, $sformatf("vec%0d", i));

    // Three back-to-back reads against a two-deep queue.
    bq.delete();
    bq.push_back(mk(1'b0, SIZE_WORD, 32'h100, 32'h0, 32'hDEAD_BEEF));
    bq.push_back(mk(1'b0, SIZE_WORD, 32'h200, 32'h0, 32'h9988_7766));
    bq.push_back(mk(1'b0, SIZE_WORD, 32'h204, 32'h0, 32'h1234_5678));
    burst(10);
    check("b2b addr_ok c0", 32'(aok_log[0]), 32'd1);
    check("b2b addr_ok c1", 32'(aok_log[1]), 32'd1);
    check("b2b addr_ok c2 full", 32'(aok_log[2]), 32'd0);
    check("b2b addr_ok c3", 32'(aok_log[3]), 32'd1);
    check("b2b data_ok count", 32'(dok_cyc.size()), 32'd3);
    if (dok_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("b2b data_ok cycle %0d", i), 32'(dok_cyc[i]), 32'(2 + 2 * i));
        check($sformatf("b2b rdata %0d", i), rd_log[i], bq[i].exp_rdata);
      end
    end

    // Write then read of the same word, both queued.
    bq.delete();
    bq.push_back(mk(1'b1, SIZE_WORD, 32'h300, 32'hCAFE_F00D, 32'h0));
    bq.push_back(mk(1'b0, SIZE_WORD, 32'h300, 32'h0, 32'hCAFE_F00D));
    burst(8);
    check("raw data_ok count", 32'(dok_cyc.size()), 32'd2);
    if (dok_cyc.size() == 2) begin
      check("raw write data_ok cycle", 32'(dok_cyc[0]), 32'd2);
      check("raw read data_ok cycle",  32'(dok_cyc[1]), 32'd4);
      check("raw write rdata", rd_log[0], 32'h0);
      check("raw read rdata",  rd_log[1], 32'hCAFE_F00D);
    end

    // Reset with two writes outstanding: both must be discarded.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, SIZE_WORD, 32'h300, 32'h5555_5555);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, SIZE_WORD, 32'h304, 32'h6666_6666);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("midrst addr_ok %0d", c), 32'(aok1), 32'd0);
      check($sformatf("midrst data_ok %0d", c), 32'(dok1), 32'd0);
      check($sformatf("midrst rdata %0d", c), rdata1, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    ndok = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (dok1) ndok++;
    end
    check("post-reset stray data_ok", 32'(ndok), 32'd0);
    single(mk(1'b0, SIZE_WORD, 32'h300, 32'h0, 32'hCAFE_F00D), 2, "post-reset read");

    // LATENCY=1 instance.
    sel = 1;
    single(mk(1'b1, SIZE_WORD, 32'h10, 32'h0F0F_0F0F, 32'h0), 1, "l1 write");
    single(mk(1'b0, SIZE_WORD, 32'h10, 32'h0, 32'h0F0F_0F0F), 1, "l1 read");
    ndok = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (dok2) ndok++;
    end
    check("l1 idle data_ok", 32'(ndok), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
